// File: rtl/demux1_4_32_buf.sv
// demux1_4_32_buf: 1-to-4 valid/ready router; each channel owns a one-entry holding register.
// Optional per-channel drain counters are built when DEMUX_COUNT_EN is defined.
module demux1_4_32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         switch,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic [3:0]         out_valid,
  output logic [WIDTH-1:0]   out_data_0,
  output logic [WIDTH-1:0]   out_data_1,
  output logic [WIDTH-1:0]   out_data_2,
  output logic [WIDTH-1:0]   out_data_3,
  input  logic [3:0]         out_ready,
  input  logic               cnt_clr,
  output logic [4*CNT_W-1:0] cnt_bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

  ch_state_e        state_q [4];
  ch_state_e        state_d [4];
  logic [WIDTH-1:0] buf_q   [4];
  logic [WIDTH-1:0] buf_d   [4];
  logic [3:0]       full;
  logic [3:0]       drn;
  logic [3:0]       acc_vec;
  logic             acc;

  always_comb begin
    full = '0;
    for (int i = 0; i < 4; i++) full[i] = (state_q[i] == FULL);
  end

  // A full channel still accepts when its consumer drains in the same cycle.
  assign in_ready = ~full[switch] | out_ready[switch];
  assign acc      = in_valid & in_ready;
  assign drn      = full & out_ready;

  always_comb begin
    acc_vec = '0;
    if (acc) acc_vec[switch] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      buf_d[i]   = buf_q[i];
      case (state_q[i])
        EMPTY:   if (acc_vec[i]) state_d[i] = FULL;
        FULL:    if (drn[i] && !acc_vec[i]) state_d[i] = EMPTY;
        default: state_d[i] = EMPTY;
      endcase
      if (acc_vec[i]) buf_d[i] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        buf_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        buf_q[i]   <= buf_d[i];
      end
    end
  end

  assign out_valid  = full;
  assign out_data_0 = buf_q[0];
  assign out_data_1 = buf_q[1];
  assign out_data_2 = buf_q[2];
  assign out_data_3 = buf_q[3];

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) cnt_d[i] = '0;
      else if (drn[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_bus = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  // Counters absent: cnt_clr is folded in only so the port is not left dangling.
  assign cnt_bus = {(4*CNT_W){cnt_clr & 1'b0}};
`endif

endmodule

// File: tb/tb_demux1_4_32_buf.sv
// Directed bench for demux1_4_32_buf: reset, routing, streaming, simultaneous events,
// backpressure, mid-run reset and (when DEMUX_COUNT_EN is defined) counters.
module tb_demux1_4_32_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  switch;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [3:0]  out_ready;
  logic        cnt_clr;
  logic [31:0] cnt_bus;

  int total = 0;
  int bad   = 0;

  demux1_4_32_buf dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_data_0(out_data_0), .out_data_1(out_data_1),
    .out_data_2(out_data_2), .out_data_3(out_data_3),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .cnt_bus(cnt_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] words [4];

  initial begin
    words[0] = 32'hA0A0A0A0; words[1] = 32'hB1B1B1B1;
    words[2] = 32'hC2C2C2C2; words[3] = 32'hD3D3D3D3;

    // Reset for two edges with a word presented
    rst_n = 1'b0; in_valid = 1'b1; switch = 2'd2; in_data = 32'hDEADBEEF;
    out_ready = 4'b0000; cnt_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_data0", out_data_0, 32'h0);
    chk("rst_data1", out_data_1, 32'h0);
    chk("rst_data2", out_data_2, 32'h0);
    chk("rst_data3", out_data_3, 32'h0);
    chk("rst_cnt_bus", cnt_bus, 32'h0);
    for (int s = 0; s < 4; s++) begin
      switch = 2'(s); settle();
      chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post_rst_nothing_captured", {28'd0, out_valid}, 32'h0);

    // Routing with all consumers stalled
    for (int i = 0; i < 4; i++) begin
      switch = 2'(i); in_valid = 1'b1; in_data = words[i]; settle();
      chk("route_in_ready", {31'd0, in_ready}, 32'h1);
      tick();
    end
    in_valid = 1'b0; settle();
    chk("route_out_valid", {28'd0, out_valid}, 32'hF);
    chk("route_data0", out_data_0, 32'hA0A0A0A0);
    chk("route_data1", out_data_1, 32'hB1B1B1B1);
    chk("route_data2", out_data_2, 32'hC2C2C2C2);
    chk("route_data3", out_data_3, 32'hD3D3D3D3);
    switch = 2'd2; in_valid = 1'b1; in_data = 32'hEEEEEEEE; settle();
    chk("route_ch2_blocked", {31'd0, in_ready}, 32'h0);
    tick();
    in_valid = 1'b0; settle();
    chk("route_ch2_kept", out_data_2, 32'hC2C2C2C2);
    chk("route_valid_kept", {28'd0, out_valid}, 32'hF);

    // Back-to-back streaming into ch1 with its consumer ready
    out_ready = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      switch = 2'd1; in_valid = 1'b1; in_data = 32'(k); settle();
      chk("stream_in_ready", {31'd0, in_ready}, 32'h1);
      chk("stream_data1", out_data_1, (k == 1) ? 32'hB1B1B1B1 : 32'(k - 1));
      tick();
    end
    in_valid = 1'b0; settle();
    chk("stream_last", out_data_1, 32'h8);
    chk("stream_last_valid", {28'd0, out_valid}, 32'hF);
    tick();
    chk("stream_drained", {28'd0, out_valid}, 32'hD);

    // Empty everything, then load ch3=0x55 and ch0=0x11
    out_ready = 4'b1101;
    tick();
    chk("flush_valid", {28'd0, out_valid}, 32'h0);
    out_ready = 4'b0000;
    switch = 2'd3; in_valid = 1'b1; in_data = 32'h55; tick();
    switch = 2'd0; in_data = 32'h11; tick();
    in_valid = 1'b0; settle();
    chk("simul_setup", {28'd0, out_valid}, 32'h9);

    // Drain+accept on ch3 while ch0 drains
    out_ready = 4'b1001; switch = 2'd3; in_valid = 1'b1; in_data = 32'h66; settle();
    chk("simul_in_ready", {31'd0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0; out_ready = 4'b0000; settle();
    chk("simul_valid", {28'd0, out_valid}, 32'h8);
    chk("simul_data3", out_data_3, 32'h66);
`ifdef DEMUX_COUNT_EN
    chk("cnt_mid", cnt_bus, {8'd2, 8'd1, 8'd9, 8'd2});
`else
    chk("cnt_off_mid", cnt_bus, 32'h0);
`endif

    // Backpressure on ch2 while ch0/ch1 keep accepting
    switch = 2'd2; in_valid = 1'b1; in_data = 32'h77; tick();
    out_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      switch = (c % 2 == 0) ? 2'd0 : 2'd1; in_valid = 1'b1; in_data = 32'h100 + 32'(c);
      settle();
      chk("bp_data2", out_data_2, 32'h77);
      chk("bp_valid2", {31'd0, out_valid[2]}, 32'h1);
      tick();
    end
    in_valid = 1'b0; switch = 2'd2; settle();
    chk("bp_data2_end", out_data_2, 32'h77);
    chk("bp_ch2_in_ready", {31'd0, in_ready}, 32'h0);
    chk("bp_ch0_last", out_data_0, 32'h104);

    // Reset mid-operation discards held words
    rst_n = 1'b0; in_valid = 1'b1; tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 4'b0000; settle();
    chk("midrst_valid", {28'd0, out_valid}, 32'h0);
    chk("midrst_data2", out_data_2, 32'h0);
    chk("midrst_cnt", cnt_bus, 32'h0);

    // Drain 300 words from ch1
    out_ready = 4'b0010; switch = 2'd1; in_valid = 1'b1; cnt_clr = 1'b1;
    for (int n = 0; n < 300; n++) begin
      in_data = 32'(n); tick();
      cnt_clr = 1'b0;
      if (n == 100) begin
`ifdef DEMUX_COUNT_EN
        chk("cnt_100", cnt_bus, 32'd100 << 8);
`else
        chk("cnt_off_100", cnt_bus, 32'h0);
`endif
      end
    end
    in_valid = 1'b0; tick();
`ifdef DEMUX_COUNT_EN
    chk("cnt_sat", cnt_bus, 32'd255 << 8);
`else
    chk("cnt_off_sat", cnt_bus, 32'h0);
`endif
    // Clear coinciding with a ch1 drain, then one more drain
    in_valid = 1'b1; in_data = 32'hAB; tick();
    in_valid = 1'b0; cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    chk("cnt_clr", cnt_bus, 32'h0);
    in_valid = 1'b1; in_data = 32'hCD; tick();
    in_valid = 1'b0; tick();
`ifdef DEMUX_COUNT_EN
    chk("cnt_after_clr", cnt_bus, 32'd1 << 8);
`else
    chk("cnt_off_after_clr", cnt_bus, 32'h0);
`endif
    chk("end_valid", {28'd0, out_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
